// File: rtl/mips_cpu.sv
// Single-cycle 32-bit MIPS core: PC, instruction memory, register file,
// data memory and decode/execute all in one file; one instruction retires per clock.

module mips_pc #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_d,
  output logic [31:0] pc
);
  logic [31:0] PC;

  always_ff @(posedge clk) begin
    if (rst) PC <= PC_RESET;
    else     PC <= pc_d;
  end

  assign pc = PC;
endmodule

module mips_im #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 1024
) (
  input  logic [31:0] pc,
  output logic [31:0] instr
);
  localparam int unsigned IW = $clog2(IM_WORDS);

  logic [31:0]   ins_mem [0:IM_WORDS-1];
  logic [IW-1:0] idx;

  // Word index relative to the reset PC, wrapped to the memory depth
  assign idx   = IW'(((pc - PC_RESET) >> 2) % 32'(IM_WORDS));
  assign instr = ins_mem[idx];
endmodule

module mips_rf (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] regs [0:31];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? 32'h0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'h0 : regs[ra2];
endmodule

module mips_dm #(
  parameter int unsigned DM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  localparam int unsigned DW = $clog2(DM_WORDS);

  logic [31:0]   dm_mem [0:DM_WORDS-1];
  logic [DW-1:0] idx;

  assign idx   = DW'((addr >> 2) % 32'(DM_WORDS));
  assign rdata = dm_mem[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DM_WORDS); i++) dm_mem[i] <= 32'h0;
    end else if (we) begin
      dm_mem[idx] <= wdata;
    end
  end
endmodule

module mips_cpu #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 1024,
  parameter int unsigned DM_WORDS = 1024
) (
  input logic clk,
  input logic rst
);
  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  logic [31:0] instr;
  logic [31:0] pc, pc_d, pc_plus4, br_target, j_target;
  logic [31:0] rs_val, rt_val, sext, zext, mem_addr, dm_rdata;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic        rf_we, dm_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  mips_pc #(.PC_RESET(PC_RESET)) U_PC (
    .clk(clk), .rst(rst), .pc_d(pc_d), .pc(pc)
  );

  mips_im #(.PC_RESET(PC_RESET), .IM_WORDS(IM_WORDS)) U_IM (
    .pc(pc), .instr(instr)
  );

  mips_rf U_RF (
    .clk(clk), .rst(rst), .ra1(rs), .ra2(rt), .rd1(rs_val), .rd2(rt_val),
    .we(rf_we), .wa(rf_wa), .wd(rf_wd)
  );

  mips_dm #(.DM_WORDS(DM_WORDS)) U_DM (
    .clk(clk), .rst(rst), .addr(mem_addr), .we(dm_we), .wdata(rt_val), .rdata(dm_rdata)
  );

  assign opcode    = instr[31:26];
  assign rs        = instr[25:21];
  assign rt        = instr[20:16];
  assign rd        = instr[15:11];
  assign shamt     = instr[10:6];
  assign funct     = instr[5:0];
  assign sext      = {{16{instr[15]}}, instr[15:0]};
  assign zext      = {16'h0, instr[15:0]};
  assign pc_plus4  = pc + 32'd4;
  assign br_target = pc_plus4 + {sext[29:0], 2'b00};
  assign j_target  = {pc_plus4[31:28], instr[25:0], 2'b00};
  assign mem_addr  = rs_val + sext;

  // Decode and execute; anything unrecognised falls through as a NOP
  always_comb begin
    rf_we = 1'b0;
    rf_wa = rd;
    rf_wd = 32'h0;
    dm_we = 1'b0;
    pc_d  = pc_plus4;
    case (opcode)
      OP_R: begin
        rf_we = 1'b1;
        case (funct)
          FN_SLL:          rf_wd = rt_val << shamt;
          FN_SRL:          rf_wd = rt_val >> shamt;
          FN_SRA:          rf_wd = 32'($signed(rt_val) >>> shamt);
          FN_SLLV:         rf_wd = rt_val << rs_val[4:0];
          FN_SRLV:         rf_wd = rt_val >> rs_val[4:0];
          FN_SRAV:         rf_wd = 32'($signed(rt_val) >>> rs_val[4:0]);
          FN_ADD, FN_ADDU: rf_wd = rs_val + rt_val;
          FN_SUB, FN_SUBU: rf_wd = rs_val - rt_val;
          FN_AND:          rf_wd = rs_val & rt_val;
          FN_OR:           rf_wd = rs_val | rt_val;
          FN_XOR:          rf_wd = rs_val ^ rt_val;
          FN_NOR:          rf_wd = ~(rs_val | rt_val);
          FN_SLT:          rf_wd = {31'd0, $signed(rs_val) < $signed(rt_val)};
          FN_SLTU:         rf_wd = {31'd0, rs_val < rt_val};
          FN_JR: begin
            rf_we = 1'b0;
            pc_d  = rs_val;
          end
          FN_JALR: begin
            rf_wd = pc_plus4;
            pc_d  = rs_val;
          end
          default:         rf_we = 1'b0;
        endcase
      end
      OP_J:   pc_d = j_target;
      OP_JAL: begin
        rf_we = 1'b1;
        rf_wa = 5'd31;
        rf_wd = pc_plus4;
        pc_d  = j_target;
      end
      OP_BEQ: if (rs_val == rt_val) pc_d = br_target;
      OP_BNE: if (rs_val != rt_val) pc_d = br_target;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
        rf_we = 1'b1;
        rf_wa = rt;
        case (opcode)
          OP_SLTI:  rf_wd = {31'd0, $signed(rs_val) < $signed(sext)};
          OP_SLTIU: rf_wd = {31'd0, rs_val < sext};
          OP_ANDI:  rf_wd = rs_val & zext;
          OP_ORI:   rf_wd = rs_val | zext;
          OP_XORI:  rf_wd = rs_val ^ zext;
          OP_LUI:   rf_wd = {instr[15:0], 16'h0};
          OP_LW:    rf_wd = dm_rdata;
          default:  rf_wd = rs_val + sext;
        endcase
      end
      OP_SW:   dm_we = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mips_cpu.sv
// Self-checking bench for mips_cpu: programs are preloaded into U_IM, expected
// per-instruction results are queued and compared as each instruction retires.

module tb_mips_cpu;
  logic clk = 1'b0;
  logic rst = 1'b1;

  mips_cpu dut (.clk(clk), .rst(rst));

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  r;
    logic [31:0] v;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] prog[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_ins(input logic [5:0] op, input logic [31:0] addr);
    return {op, addr[27:2]};
  endfunction

  task automatic expect_at(input string n, input logic [4:0] r, input logic [31:0] v,
                           input logic [31:0] pc);
    exp_t e;
    e.name = n; e.r = r; e.v = v; e.pc = pc;
    sb.push_back(e);
  endtask

  // Straight-line step: next PC is simply the following word
  task automatic step(input string n, input logic [31:0] w, input logic [4:0] r,
                      input logic [31:0] v);
    prog.push_back(w);
    expect_at(n, r, v, 32'h3000 + 32'(prog.size()) * 32'd4);
  endtask

  task automatic start();
    for (int i = 0; i < 1024; i++) dut.U_IM.ins_mem[i] = 32'h0;
    foreach (prog[i]) dut.U_IM.ins_mem[i] = prog[i];
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Scoreboard consumer: one entry per retired instruction
  task automatic drain();
    exp_t e;
    logic [31:0] got;
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      e   = sb.pop_front();
      got = dut.U_RF.regs[e.r];
      n_checks++;
      if (got !== e.v) $display("FAIL %s reg $%0d: got %h expected %h", e.name, e.r, got, e.v);
      else n_pass++;
      n_checks++;
      if (dut.U_PC.PC !== e.pc) $display("FAIL %s pc: got %h expected %h", e.name, dut.U_PC.PC, e.pc);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    prog.delete();
    prog.push_back(i_ins(6'h0D, 5'd0, 5'd1, 16'h0055));
    prog.push_back(i_ins(6'h2B, 5'd0, 5'd1, 16'h0004));
    prog.push_back(i_ins(6'h0F, 5'd0, 5'd31, 16'hABCD));
    start();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (dut.U_RF.regs[1] !== 32'h55) $display("FAIL dirty_r1: got %h expected %h", dut.U_RF.regs[1], 32'h55);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (dut.U_PC.PC !== 32'h3000) $display("FAIL reset_pc: got %h expected %h", dut.U_PC.PC, 32'h3000);
    else n_pass++;
    n_checks++;
    if (dut.instr !== prog[0]) $display("FAIL reset_instr: got %h expected %h", dut.instr, prog[0]);
    else n_pass++;
    for (int i = 0; i < 32; i++) begin
      n_checks++;
      if (dut.U_RF.regs[i] !== 32'h0) $display("FAIL reset_gpr%0d: got %h expected 0", i, dut.U_RF.regs[i]);
      else n_pass++;
    end
    n_checks++;
    if (dut.U_DM.dm_mem[1] !== 32'h0) $display("FAIL reset_dm1: got %h expected 0", dut.U_DM.dm_mem[1]);
    else n_pass++;
  endtask

  task automatic test_alu();
    prog.delete();
    step("ori",   i_ins(6'h0D, 5'd0, 5'd1, 16'h1234),  5'd1,  32'h0000_1234);
    step("lui",   i_ins(6'h0F, 5'd0, 5'd2, 16'hFFFF),  5'd2,  32'hFFFF_0000);
    step("addu",  r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 5'd3,  32'hFFFF_1234);
    step("subu",  r_ins(5'd1, 5'd1, 5'd4, 5'd0, 6'h23), 5'd4,  32'h0);
    step("slt",   r_ins(5'd2, 5'd1, 5'd5, 5'd0, 6'h2A), 5'd5,  32'h1);
    step("sltu",  r_ins(5'd2, 5'd1, 5'd6, 5'd0, 6'h2B), 5'd6,  32'h0);
    step("r0",    i_ins(6'h0D, 5'd0, 5'd0, 16'h0005),  5'd0,  32'h0);
    step("nor",   r_ins(5'd1, 5'd0, 5'd10, 5'd0, 6'h27), 5'd10, 32'hFFFF_EDCB);
    step("addiu", i_ins(6'h09, 5'd0, 5'd11, 16'hFFFF), 5'd11, 32'hFFFF_FFFF);
    step("sltiu", i_ins(6'h0B, 5'd1, 5'd12, 16'hFFFF), 5'd12, 32'h1);
    step("andi",  i_ins(6'h0C, 5'd11, 5'd13, 16'hFFFF), 5'd13, 32'h0000_FFFF);
    step("slti",  i_ins(6'h0A, 5'd11, 5'd14, 16'h0000), 5'd14, 32'h1);
    step("subu2", r_ins(5'd0, 5'd1, 5'd15, 5'd0, 6'h23), 5'd15, 32'hFFFF_EDCC);
    step("and",   r_ins(5'd3, 5'd10, 5'd16, 5'd0, 6'h24), 5'd16, 32'hFFFF_0000);
    step("or",    r_ins(5'd1, 5'd2, 5'd17, 5'd0, 6'h25), 5'd17, 32'hFFFF_1234);
    step("xori",  i_ins(6'h0E, 5'd1, 5'd18, 16'hFFFF), 5'd18, 32'h0000_EDCB);
    step("add",   r_ins(5'd1, 5'd1, 5'd19, 5'd0, 6'h20), 5'd19, 32'h0000_2468);
    step("sub",   r_ins(5'd0, 5'd11, 5'd20, 5'd0, 6'h22), 5'd20, 32'h1);
    step("addi",  i_ins(6'h08, 5'd11, 5'd21, 16'hFFFF), 5'd21, 32'hFFFF_FFFE);
    start();
    drain();
  endtask

  task automatic test_shift();
    prog.delete();
    step("lui",  i_ins(6'h0F, 5'd0, 5'd2, 16'hFFFF),    5'd2,  32'hFFFF_0000);
    step("sra",  r_ins(5'd0, 5'd2, 5'd7, 5'd4, 6'h03),   5'd7,  32'hFFFF_F000);
    step("srl",  r_ins(5'd0, 5'd2, 5'd8, 5'd4, 6'h02),   5'd8,  32'h0FFF_F000);
    step("ori8", i_ins(6'h0D, 5'd0, 5'd9, 16'h0008),    5'd9,  32'h8);
    step("sllv", r_ins(5'd9, 5'd2, 5'd10, 5'd0, 6'h04),  5'd10, 32'hFF00_0000);
    step("sll",  r_ins(5'd0, 5'd2, 5'd11, 5'd4, 6'h00),  5'd11, 32'hFFF0_0000);
    step("neg",  i_ins(6'h09, 5'd0, 5'd12, 16'hFF00),   5'd12, 32'hFFFF_FF00);
    step("srav", r_ins(5'd9, 5'd12, 5'd13, 5'd0, 6'h07), 5'd13, 32'hFFFF_FFFF);
    step("ori40", i_ins(6'h0D, 5'd0, 5'd15, 16'h0028),  5'd15, 32'h28);
    step("srlv", r_ins(5'd15, 5'd12, 5'd16, 5'd0, 6'h06), 5'd16, 32'h00FF_FFFF);
    start();
    drain();
  endtask

  task automatic test_mem();
    prog.delete();
    step("ori",   i_ins(6'h0D, 5'd0, 5'd1, 16'h1234),  5'd1,  32'h0000_1234);
    step("lui",   i_ins(6'h0F, 5'd0, 5'd2, 16'hFFFF),  5'd2,  32'hFFFF_0000);
    step("addu",  r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 5'd3,  32'hFFFF_1234);
    step("sw8",   i_ins(6'h2B, 5'd0, 5'd3, 16'h0008),  5'd0,  32'h0);
    step("lw8",   i_ins(6'h23, 5'd0, 5'd9, 16'h0008),  5'd9,  32'hFFFF_1234);
    step("lw0a",  i_ins(6'h23, 5'd0, 5'd10, 16'h000A), 5'd10, 32'hFFFF_1234);
    step("base",  i_ins(6'h09, 5'd0, 5'd20, 16'h0010), 5'd20, 32'h10);
    step("swneg", i_ins(6'h2B, 5'd20, 5'd1, 16'hFFFC), 5'd0,  32'h0);
    step("lw12",  i_ins(6'h23, 5'd0, 5'd11, 16'h000C), 5'd11, 32'h0000_1234);
    step("lwwrap", i_ins(6'h23, 5'd0, 5'd12, 16'h1008), 5'd12, 32'hFFFF_1234);
    start();
    drain();
    n_checks++;
    if (dut.U_DM.dm_mem[2] !== 32'hFFFF_1234) $display("FAIL dm_word2: got %h expected %h", dut.U_DM.dm_mem[2], 32'hFFFF_1234);
    else n_pass++;
    n_checks++;
    if (dut.U_DM.dm_mem[3] !== 32'h0000_1234) $display("FAIL dm_word3: got %h expected %h", dut.U_DM.dm_mem[3], 32'h0000_1234);
    else n_pass++;
  endtask

  task automatic test_control();
    prog.delete();
    prog.push_back(i_ins(6'h04, 5'd0, 5'd0, 16'h0002));        // 3000 beq +2
    prog.push_back(i_ins(6'h0D, 5'd0, 5'd1, 16'h0001));        // 3004 skipped
    prog.push_back(i_ins(6'h0D, 5'd0, 5'd1, 16'h0002));        // 3008 skipped
    prog.push_back(i_ins(6'h05, 5'd0, 5'd0, 16'h0005));        // 300C bne not taken
    prog.push_back(j_ins(6'h03, 32'h3020));                    // 3010 jal
    prog.push_back(i_ins(6'h0D, 5'd0, 5'd2, 16'h0077));        // 3014
    prog.push_back(j_ins(6'h02, 32'h3028));                    // 3018 j
    prog.push_back(32'h0);                                     // 301C
    prog.push_back(r_ins(5'd31, 5'd0, 5'd0, 5'd0, 6'h08));     // 3020 jr $31
    prog.push_back(32'h0);                                     // 3024
    prog.push_back(i_ins(6'h0D, 5'd0, 5'd4, 16'h3040));        // 3028
    prog.push_back(r_ins(5'd4, 5'd0, 5'd4, 5'd0, 6'h09));      // 302C jalr $4,$4
    prog.push_back(32'h0);
    prog.push_back(32'h0);
    prog.push_back(32'h0);
    prog.push_back(i_ins(6'h04, 5'd1, 5'd0, 16'h0003));        // 303C beq +3
    prog.push_back(i_ins(6'h05, 5'd4, 5'd0, 16'hFFFE));        // 3040 bne -2
    expect_at("beq_taken", 5'd0,  32'h0,    32'h300C);
    expect_at("bne_fall",  5'd0,  32'h0,    32'h3010);
    expect_at("jal",       5'd31, 32'h3014, 32'h3020);
    expect_at("jr",        5'd0,  32'h0,    32'h3014);
    expect_at("after_jr",  5'd2,  32'h77,   32'h3018);
    expect_at("j",         5'd0,  32'h0,    32'h3028);
    expect_at("ori_tgt",   5'd4,  32'h3040, 32'h302C);
    expect_at("jalr",      5'd4,  32'h3030, 32'h3040);
    expect_at("bne_back",  5'd0,  32'h0,    32'h303C);
    expect_at("beq_fwd",   5'd0,  32'h0,    32'h304C);
    start();
    drain();
    n_checks++;
    if (dut.U_RF.regs[1] !== 32'h0) $display("FAIL skipped_r1: got %h expected 0", dut.U_RF.regs[1]);
    else n_pass++;
  endtask

  task automatic test_loop();
    prog.delete();
    prog.push_back(i_ins(6'h09, 5'd0, 5'd1, 16'h0005));        // 3000 $1 = 5
    prog.push_back(i_ins(6'h09, 5'd2, 5'd2, 16'h0001));        // 3004 $2++
    prog.push_back(i_ins(6'h09, 5'd1, 5'd1, 16'hFFFF));        // 3008 $1--
    prog.push_back(i_ins(6'h05, 5'd1, 5'd0, 16'hFFFD));        // 300C bne -> 3004
    prog.push_back({6'h3F, 5'd1, 5'd2, 16'h0001});             // 3010 undefined opcode
    prog.push_back(r_ins(5'd1, 5'd2, 5'd5, 5'd0, 6'h01));      // 3014 undefined funct
    prog.push_back(i_ins(6'h0D, 5'd0, 5'd3, 16'h0009));        // 3018
    expect_at("init", 5'd1, 32'd5, 32'h3004);
    for (int k = 1; k <= 5; k++) begin
      expect_at("iter", 5'd2, 32'(k), 32'h3008);
      expect_at("dec",  5'd1, 32'(5 - k), 32'h300C);
      expect_at("bne",  5'd0, 32'h0, (k < 5) ? 32'h3004 : 32'h3010);
    end
    expect_at("undef_op", 5'd2, 32'd5, 32'h3014);
    expect_at("undef_fn", 5'd5, 32'h0, 32'h3018);
    expect_at("post",     5'd3, 32'h9, 32'h301C);
    start();
    drain();
    n_checks++;
    if (dut.U_RF.regs[1] !== 32'h0) $display("FAIL loop_final: got %h expected 0", dut.U_RF.regs[1]);
    else n_pass++;
    n_checks++;
    if (dut.U_DM.dm_mem[0] !== 32'h0) $display("FAIL undef_dm0: got %h expected 0", dut.U_DM.dm_mem[0]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_shift();
    test_mem();
    test_control();
    test_loop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
